// File: rtl/nes_event_pkg.sv
// Shared types and constants for the NES-EVENT timer/mapper slice.
package nes_event_pkg;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    ARMED  = 2'd1,
    OPEN   = 2'd2
  } unlock_state_t;

  localparam logic [29:0] DEF_TGT_BASE = 30'h2000000;
  localparam logic [29:0] DEF_TGT_STEP = 30'h0200000;

  localparam int I_BIT = 3;
  localparam int O_BIT = 2;

endpackage

// File: rtl/nes_event_irq_timer.sv
// IRQ timer: DIP-selected target, saturating up-counter, latched IRQ with acknowledge.
// Build option NESEVT_REMAIN_EN adds the registered remaining-count output.
module nes_event_irq_timer
  import nes_event_pkg::*;
#(
  parameter int unsigned      CNT_W    = 30,
  parameter int unsigned      DIP_W    = 4,
  parameter logic [CNT_W-1:0] TGT_BASE = CNT_W'(DEF_TGT_BASE),
  parameter logic [CNT_W-1:0] TGT_STEP = CNT_W'(DEF_TGT_STEP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             ack,
  input  logic [DIP_W-1:0] dip,
  output logic             irq,
  output logic             running,
  output logic [CNT_W-1:0] remain
);

  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic             running_q, running_d;

  // Target is recomputed combinationally so a DIP change applies on the very next ce.
  assign tgt = TGT_BASE + CNT_W'(dip) * TGT_STEP;

  // NOTE: every always_comb output gets a hold value first, so no path can infer a latch.
  always_comb begin
    cnt_d     = cnt_q;
    irq_d     = irq_q;
    running_d = running_q;
    if (ce) begin
      if (ack) begin
        cnt_d = '0;
        irq_d = 1'b0;
      end else if (cnt_q == tgt) begin
        irq_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      running_d = !ack && !irq_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      running_q <= running_d;
    end
  end

  assign irq     = irq_q;
  assign running = running_q;

`ifdef NESEVT_REMAIN_EN
  logic [CNT_W-1:0] remain_q, remain_d;

  // Forced to zero whenever the IRQ will be high after this edge.
  always_comb begin
    remain_d = remain_q;
    if (ce) remain_d = irq_d ? '0 : tgt - cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) remain_q <= '0;
    else       remain_q <= remain_d;
  end

  assign remain = remain_q;
`else
  assign remain = '0;
`endif

endmodule

// File: rtl/nes_event_timer_mapper.sv
// NES-EVENT mapper wrapper: unlock FSM, PRG/CHR address remap and the IRQ timer.
// Build option NESEVT_REMAIN_EN enables the remain output of the timer.
module nes_event_timer_mapper
  import nes_event_pkg::*;
#(
  parameter int unsigned      CNT_W        = 30,
  parameter int unsigned      DIP_W        = 4,
  parameter logic [CNT_W-1:0] TGT_BASE     = CNT_W'(DEF_TGT_BASE),
  parameter logic [CNT_W-1:0] TGT_STEP     = CNT_W'(DEF_TGT_STEP),
  parameter logic [21:0]      CHIP_B_OFS   = 22'h020000,
  parameter logic [21:0]      CHR_RAM_BASE = 22'h200000,
  parameter int unsigned      CHR_RAM_AW   = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [15:0]      prg_ain,
  output logic [21:0]      prg_aout,
  input  logic [13:0]      chr_ain,
  output logic [21:0]      chr_aout,
  input  logic [3:0]       ctrl,
  input  logic [21:0]      mmc_aout,
  input  logic [DIP_W-1:0] dip,
  output logic             irq,
  output logic             unlocked,
  output logic             running,
  output logic [CNT_W-1:0] remain
);

  unlock_state_t state_q, state_d;
  logic          unlocked_q, unlocked_d;
  logic          unused_chr_hi;

  // A 0 on I must be seen before a 1 opens the PRG swap; holding I high from reset never unlocks.
  always_comb begin
    state_d = state_q;
    if (ce) begin
      case (state_q)
        LOCKED:  if (!ctrl[I_BIT]) state_d = ARMED;
        ARMED:   if (ctrl[I_BIT])  state_d = OPEN;
        OPEN:    state_d = OPEN;
        default: state_d = LOCKED;
      endcase
    end
    unlocked_d = (state_d == OPEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOCKED;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      unlocked_q <= unlocked_d;
    end
  end

  assign unlocked = unlocked_q;

  always_comb begin
    prg_aout = mmc_aout;
    if (prg_ain[15]) begin
      if (!unlocked_q)        prg_aout = {7'b0, prg_ain[14:0]};
      else if (!ctrl[O_BIT])  prg_aout = {5'b0, ctrl[1:0], prg_ain[14:0]};
      else                    prg_aout = mmc_aout | CHIP_B_OFS;
    end
  end

  assign chr_aout      = CHR_RAM_BASE | 22'(chr_ain[CHR_RAM_AW-1:0]);
  assign unused_chr_hi = ^chr_ain;

  nes_event_irq_timer #(
    .CNT_W    (CNT_W),
    .DIP_W    (DIP_W),
    .TGT_BASE (TGT_BASE),
    .TGT_STEP (TGT_STEP)
  ) u_irq_timer (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .ack     (ctrl[I_BIT]),
    .dip     (dip),
    .irq     (irq),
    .running (running),
    .remain  (remain)
  );

endmodule

// File: tb/tb_nes_event_timer_mapper.sv
// Self-checking bench for nes_event_timer_mapper (CNT_W=8, TGT_BASE=8'h20, TGT_STEP=8'h04).
module tb_nes_event_timer_mapper;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [15:0] prg_ain;
  logic [21:0] prg_aout, mmc_aout, chr_aout;
  logic [13:0] chr_ain;
  logic [3:0]  ctrl, dip;
  logic        irq, unlocked, running;
  logic [7:0]  remain;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integer view of the timer and unlock rules.
  int m_cnt, m_rem;
  bit m_irq, m_run, m_armed, m_open;

  nes_event_timer_mapper #(
    .CNT_W    (8),
    .DIP_W    (4),
    .TGT_BASE (8'h20),
    .TGT_STEP (8'h04)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .prg_ain  (prg_ain),
    .prg_aout (prg_aout),
    .chr_ain  (chr_ain),
    .chr_aout (chr_aout),
    .ctrl     (ctrl),
    .mmc_aout (mmc_aout),
    .dip      (dip),
    .irq      (irq),
    .unlocked (unlocked),
    .running  (running),
    .remain   (remain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] prg_ref(input logic [15:0] a, input logic [3:0] c,
                                          input logic [21:0] m, input bit unl);
    if (!a[15])    return m;
    if (!unl)      return {7'b0, a[14:0]};
    if (!c[2])     return {5'b0, c[1:0], a[14:0]};
    return m | 22'h020000;
  endfunction

  // Advance the model by one clock edge using the inputs present before that edge.
  task automatic model_step();
    int tgt;
    bit n_irq;
    if (reset) begin
      m_cnt = 0; m_rem = 0; m_irq = 0; m_run = 0; m_armed = 0; m_open = 0;
      return;
    end
    if (!ce) return;
    tgt = (32 + 4 * int'(dip)) % 256;
    if (!m_open) begin
      if (m_armed && ctrl[3]) m_open = 1;
      else if (!ctrl[3])      m_armed = 1;
    end
    m_run = !ctrl[3] && !m_irq;
    n_irq = ctrl[3] ? 1'b0 : (m_irq || (m_cnt == tgt));
    m_rem = n_irq ? 0 : (tgt - m_cnt + 256) % 256;
    if (ctrl[3])           m_cnt = 0;
    else if (m_cnt != tgt) m_cnt = (m_cnt + 1) % 256;
    m_irq = n_irq;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".irq"}, 32'(irq), 32'(m_irq));
    check({tag, ".running"}, 32'(running), 32'(m_run));
    check({tag, ".unlocked"}, 32'(unlocked), 32'(m_open));
`ifdef NESEVT_REMAIN_EN
    check({tag, ".remain"}, 32'(remain), 32'(m_rem));
`else
    check({tag, ".remain"}, 32'(remain), 32'(0));
`endif
    prg_ain  = 16'($urandom);
    mmc_aout = 22'($urandom);
    chr_ain  = 14'($urandom);
    #1;
    check({tag, ".prg"}, 32'(prg_aout), 32'(prg_ref(prg_ain, ctrl, mmc_aout, m_open)));
    check({tag, ".chr"}, 32'(chr_aout), 32'(22'h200000 | {9'b0, chr_ain[12:0]}));
  endtask

  initial begin
    int n;
    reset = 1'b1; ce = 1'b1; ctrl = 4'hF; dip = 4'd0;
    prg_ain = '0; mmc_aout = '0; chr_ain = '0;

    repeat (3) tick("reset");
    reset = 1'b0;
    repeat (10) tick("hold_i");

    prg_ain = 16'h9234; #1;
    check("locked_prg", 32'(prg_aout), 32'h001234);
    check("locked_unl", 32'(unlocked), 32'(0));

    ctrl = 4'b0011; tick("arm");
    ctrl = 4'b1011; tick("open");
    check("unlock_3rd", 32'(unlocked), 32'(1));
    prg_ain = 16'h8000; #1;
    check("bank_a", 32'(prg_aout), 32'h018000);
    ctrl = 4'b1111; mmc_aout = 22'h004000; #1;
    check("chip_b", 32'(prg_aout), 32'h024000);

    // Count from 0 to tgt=8'h28; the IRQ must follow one cycle after the match.
    dip = 4'd2; ctrl = 4'b0100;
    for (int i = 1; i <= 41; i++) begin
      tick("count");
`ifdef NESEVT_REMAIN_EN
      if (i == 17) check("remain_10", 32'(remain), 32'h18);
`endif
      if (i == 40) check("irq_pre", 32'(irq), 32'(0));
    end
    check("irq_41", 32'(irq), 32'(1));
    prg_ain = 16'h6010; mmc_aout = 22'h2ABCDE; #1;
    check("wram", 32'(prg_aout), 32'h2ABCDE);
    repeat (100) tick("irq_hold");
    check("irq_100", 32'(irq), 32'(1));

    ctrl = 4'b1100; tick("ack");
    check("ack_irq", 32'(irq), 32'(0));
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ctrl = {1'b0, 3'($urandom)};
      dip  = 4'($urandom);
      tick("ce_low");
    end
    ce = 1'b1;

    // Reach 8'h30 with tgt=8'h34, then drop tgt to 8'h28 so the counter must wrap.
    dip = 4'd5; ctrl = 4'b0100;
    repeat (8'h30) tick("pre_wrap");
    dip = 4'd2;
    n = 0;
    while (!irq && n < 400) begin
      tick("wrap");
      n++;
    end
    check("wrap_len", 32'(n), 32'd249);

    ctrl = 4'b1100; tick("ack2");
    ctrl = 4'b0100; repeat (10) tick("mid");
    reset = 1'b1; tick("mid_rst");
    check("mid_rst_unl", 32'(unlocked), 32'(0));
    reset = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      ce    = ($urandom_range(0, 3) != 0);
      ctrl  = {($urandom_range(0, 80) == 0), 3'($urandom)};
      if ($urandom_range(0, 50) == 0) dip = 4'($urandom);
      reset = ($urandom_range(0, 600) == 0);
      tick("rand");
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
